next_pc_unit: RTL and testbench
===============================

Name: next_pc_unit

Overview:
- Sequential PC register and next-address sequencer for the MIPS32 fetch stage.
- Works as the consumer end of jump/branch target composition. It takes the raw 26-bit J-type index, the 16-bit branch immediate, or a register target, and builds the redirect address internally from its own PC+4.
- Provides a fetch handshake, stall handling, a one-deep pending-redirect buffer, and a misaligned-JR trap.
- Drives the instruction-memory address; sits between control/ALU outputs and instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC value loaded on a misaligned JR trap.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_ready  input  1  instruction memory accepts the current pc this cycle.
- stall  input  1  hazard hold; PC must not advance while high.
- branch_taken  input  1  redirect request: PC+4 + (sign-extended branch_imm << 2).
- branch_imm  input  16  branch offset in words.
- jump_en  input  1  redirect request: {pcplus4[31:28], jump_index, 2'b00}.
- jump_index  input  26  J-type index field.
- jr_en  input  1  redirect request to jr_target.
- jr_target  input  32  register jump target.
- pc  output  32  current fetch address.
- pcplus4  output  32  pc + 4, combinational, modulo 2^32.
- pc_valid  output  1  pc is a valid fetch address.
- exc_flag  output  1  one-cycle pulse on misaligned-JR trap.
- epc  output  32  pc of the faulting JR, held until the next trap or reset.

Behaviour:
- Reset (synchronous, highest priority, valid mid-operation):
  - pc=RESET_PC, pc_valid=0, exc_flag=0, epc=0.
  - Pending buffer cleared; state=BOOT.
- States:
  - BOOT: one cycle, pc_valid=0, then RUN unconditionally.
  - RUN: pc_valid=1, no pending redirect.
  - PEND: pc_valid=1, a redirect target is held in the pending buffer.
- advance = pc_valid & fetch_ready & ~stall.
- Redirect priority per cycle: jr_en > jump_en > branch_taken. Lower-priority requests in the same cycle are ignored.
- Targets are computed in the request cycle from the current pc/pcplus4:
  - Branch: pcplus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00}, wraps modulo 2^32.
  - Jump: upper 4 bits always taken from pcplus4, so a pc of 0x0FFF_FFFC lands in region 0x1.
  - JR: jr_target used as-is.
- Misaligned JR (jr_en & jr_target[1:0]!=0):
  - Target is replaced with EXC_VECTOR.
  - epc<=pc in the request cycle; exc_flag=1 the next cycle for exactly one cycle.
  - The trap is recorded even if advance=0.
- RUN, advance=1:
  - Redirect present: pc<=target.
  - No redirect: pc<=pcplus4.
  - Stay in RUN.
- RUN, advance=0:
  - Redirect present: target latched into pending, go to PEND; pc held.
  - No redirect: pc held.
- PEND, advance=1:
  - New redirect present: pc<=new target (newest wins).
  - No new redirect: pc<=pending.
  - Clear pending, go to RUN.
- PEND, advance=0:
  - New redirect overwrites pending (latest wins).
  - pc held, stay in PEND.
- Latency: a redirect with advance=1 appears on pc the next cycle. A buffered redirect appears the cycle after the first advance.
- stall=1 and fetch_ready=0 together have the same effect as either alone.

Test Plan:
- Reset/sequential: reset one cycle, fetch_ready=1, stall=0 -> pc=0x0 with pc_valid=0 for one cycle, then 0x0, 0x4, 0x8 with pc_valid=1.
- Jump region: pc=0x0FFF_FFFC, jump_en=1, jump_index=0x0000040 -> next pc=0x1000_0100.
- Branch: pc=0x0000_0100, branch_taken=1, branch_imm=0xFFFF -> pc=0x0000_0100. branch_imm=0x0004 -> pc=0x0000_0114.
- Stall buffering: pc=0x200, jump_en with jump_index=0x80 during stall=1; 3 stall cycles, then a branch with imm 0x1 while still stalled -> pc held at 0x200 throughout; after release pc=0x208 (newest wins).
- Misaligned JR: pc=0x300, jr_en=1, jr_target=0x0000_1002 -> next pc=0x80, exc_flag high exactly one cycle, epc=0x300. Aligned 0x1000 -> pc=0x1000, no trap.
- Reset mid-PEND: pending redirect held, reset asserted -> pc=0x0, pending discarded, BOOT cycle, then sequential from 0x0.

Source files
------------

// File: rtl/next_pc_unit.sv
// MIPS32 fetch-stage PC register: sequential advance, jump/branch/JR redirect,
// a one-deep pending-redirect buffer for stalled cycles, and a misaligned-JR trap.
module next_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump_en,
    input  logic [25:0] jump_index,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        pc_valid,
    output logic        exc_flag,
    output logic [31:0] epc
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_q;
    logic [31:0] epc_q;
    logic        pc_valid_q;
    logic        exc_flag_q;

    logic        advance_d;
    logic        redir_d;
    logic        trap_d;
    logic [31:0] redir_tgt_d;
    logic [31:0] branch_tgt_d;
    logic [31:0] jump_tgt_d;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        pcplus4      = pc_q + 32'd4;
        advance_d    = pc_valid_q & fetch_ready & ~stall;
        branch_tgt_d = pcplus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
        jump_tgt_d   = {pcplus4[31:28], jump_index, 2'b00};
        trap_d       = jr_en & (jr_target[1:0] != 2'b00);
        redir_d      = jr_en | jump_en | branch_taken;
        redir_tgt_d  = branch_tgt_d;
        // Priority jr > jump > branch; a misaligned JR is steered to the trap vector.
        if (jr_en) begin
            redir_tgt_d = trap_d ? EXC_VECTOR : jr_target;
        end else if (jump_en) begin
            redir_tgt_d = jump_tgt_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            epc_q      <= '0;
            pc_valid_q <= 1'b0;
            exc_flag_q <= 1'b0;
        end else begin
            exc_flag_q <= 1'b0;
            if (state_q != BOOT && trap_d) begin
                exc_flag_q <= 1'b1;
                epc_q      <= pc_q;
            end
            unique case (state_q)
                BOOT: begin
                    state_q    <= RUN;
                    pc_valid_q <= 1'b1;
                end
                RUN: begin
                    if (advance_d) begin
                        pc_q <= redir_d ? redir_tgt_d : pcplus4;
                    end else if (redir_d) begin
                        pend_q  <= redir_tgt_d;
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (advance_d) begin
                        pc_q    <= redir_d ? redir_tgt_d : pend_q;
                        pend_q  <= '0;
                        state_q <= RUN;
                    end else if (redir_d) begin
                        pend_q <= redir_tgt_d;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;
    assign exc_flag = exc_flag_q;
    assign epc      = epc_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit: sequencing, redirect targets,
// stall buffering, misaligned-JR trap and reset while a redirect is pending.
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_ready;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump_en;
    logic [25:0] jump_index;
    logic        jr_en;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        pc_valid;
    logic        exc_flag;
    logic [31:0] epc;

    int checks = 0;
    int errors = 0;

    next_pc_unit dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_ready  (fetch_ready),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump_en      (jump_en),
        .jump_index   (jump_index),
        .jr_en        (jr_en),
        .jr_target    (jr_target),
        .pc           (pc),
        .pcplus4      (pcplus4),
        .pc_valid     (pc_valid),
        .exc_flag     (exc_flag),
        .epc          (epc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge, inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req();
        branch_taken = 1'b0;
        jump_en      = 1'b0;
        jr_en        = 1'b0;
        branch_imm   = '0;
        jump_index   = '0;
        jr_target    = '0;
    endtask

    task automatic jr_to(input logic [31:0] tgt);
        jr_en     = 1'b1;
        jr_target = tgt;
        tick();
        idle_req();
    endtask

    initial begin
        idle_req();
        reset       = 1'b1;
        fetch_ready = 1'b1;
        stall       = 1'b0;
        #2;

        // Reset, BOOT, then sequential fetch
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'b0, pc_valid}, 32'd0);
        check("rst_exc", {31'b0, exc_flag}, 32'd0);
        check("rst_epc", epc, 32'h0);
        reset = 1'b0;
        tick();
        check("boot_pc", pc, 32'h0);
        check("boot_valid", {31'b0, pc_valid}, 32'd1);
        tick();
        check("seq_pc4", pc, 32'h4);
        tick();
        check("seq_pc8", pc, 32'h8);

        // Jump takes its region bits from pcplus4
        jr_to(32'h0FFF_FFFC);
        check("jr_region_pc", pc, 32'h0FFF_FFFC);
        check("pcplus4_region", pcplus4, 32'h1000_0000);
        jump_en    = 1'b1;
        jump_index = 26'h0000040;
        tick();
        idle_req();
        check("jump_region", pc, 32'h1000_0100);

        // pcplus4 and branch target wrap modulo 2^32
        jr_to(32'hFFFF_FFFC);
        check("pcplus4_wrap", pcplus4, 32'h0);
        branch_taken = 1'b1;
        branch_imm   = 16'h0001;
        tick();
        idle_req();
        check("branch_wrap", pc, 32'h4);

        // Branch offsets: -1 word and +4 words
        jr_to(32'h0000_0100);
        branch_taken = 1'b1;
        branch_imm   = 16'hFFFF;
        tick();
        idle_req();
        check("branch_neg", pc, 32'h0000_0100);
        branch_taken = 1'b1;
        branch_imm   = 16'h0004;
        tick();
        idle_req();
        check("branch_pos", pc, 32'h0000_0114);

        // Redirect priority
        jr_en = 1'b1; jr_target = 32'h400;
        jump_en = 1'b1; jump_index = 26'h10;
        branch_taken = 1'b1; branch_imm = 16'h1;
        tick();
        idle_req();
        check("prio_jr", pc, 32'h400);
        jump_en = 1'b1; jump_index = 26'h10;
        branch_taken = 1'b1; branch_imm = 16'h1;
        tick();
        idle_req();
        check("prio_jump", pc, 32'h40);

        // Stall buffering: latest redirect wins after release
        jr_to(32'h200);
        stall      = 1'b1;
        jump_en    = 1'b1;
        jump_index = 26'h80;
        tick();
        idle_req();
        check("stall_hold0", pc, 32'h200);
        check("stall_valid", {31'b0, pc_valid}, 32'd1);
        tick();
        check("stall_hold1", pc, 32'h200);
        tick();
        check("stall_hold2", pc, 32'h200);
        branch_taken = 1'b1;
        branch_imm   = 16'h0001;
        tick();
        idle_req();
        check("stall_hold3", pc, 32'h200);
        stall = 1'b0;
        tick();
        check("stall_newest", pc, 32'h208);
        tick();
        check("stall_after", pc, 32'h20C);

        // fetch_ready=0 buffers exactly like stall; pending drains on first advance
        fetch_ready = 1'b0;
        jump_en     = 1'b1;
        jump_index  = 26'h100;
        tick();
        idle_req();
        check("frdy_hold0", pc, 32'h20C);
        tick();
        check("frdy_hold1", pc, 32'h20C);
        fetch_ready = 1'b1;
        tick();
        check("frdy_pending", pc, 32'h400);

        // Pending overridden by a redirect arriving in the advance cycle
        stall      = 1'b1;
        jump_en    = 1'b1;
        jump_index = 26'h200;
        tick();
        idle_req();
        check("pend_hold", pc, 32'h400);
        stall     = 1'b0;
        jr_en     = 1'b1;
        jr_target = 32'h1000;
        tick();
        idle_req();
        check("pend_new_wins", pc, 32'h1000);

        // Misaligned JR trap
        jr_to(32'h300);
        jr_en     = 1'b1;
        jr_target = 32'h0000_1002;
        tick();
        idle_req();
        check("trap_pc", pc, 32'h80);
        check("trap_exc", {31'b0, exc_flag}, 32'd1);
        check("trap_epc", epc, 32'h300);
        tick();
        check("trap_exc_once", {31'b0, exc_flag}, 32'd0);
        check("trap_pc_next", pc, 32'h84);
        jr_to(32'h1000);
        check("jr_aligned_pc", pc, 32'h1000);
        check("jr_aligned_exc", {31'b0, exc_flag}, 32'd0);
        check("epc_held", epc, 32'h300);

        // Trap recorded while stalled; vector applied on release
        stall     = 1'b1;
        jr_en     = 1'b1;
        jr_target = 32'h1001;
        tick();
        idle_req();
        check("stall_trap_pc", pc, 32'h1000);
        check("stall_trap_exc", {31'b0, exc_flag}, 32'd1);
        check("stall_trap_epc", epc, 32'h1000);
        tick();
        check("stall_trap_once", {31'b0, exc_flag}, 32'd0);
        stall = 1'b0;
        tick();
        check("stall_trap_vec", pc, 32'h80);

        // Reset while a redirect is pending
        stall      = 1'b1;
        jump_en    = 1'b1;
        jump_index = 26'h300;
        tick();
        idle_req();
        check("pend_before_rst", pc, 32'h80);
        stall = 1'b0;
        reset = 1'b1;
        tick();
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_valid", {31'b0, pc_valid}, 32'd0);
        check("mid_rst_epc", epc, 32'h0);
        reset = 1'b0;
        tick();
        check("mid_boot_pc", pc, 32'h0);
        check("mid_boot_valid", {31'b0, pc_valid}, 32'd1);
        tick();
        check("mid_seq4", pc, 32'h4);
        tick();
        check("mid_seq8", pc, 32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
